chunked_adder_subtractor: RTL and testbench
===========================================

Name: chunked_adder_subtractor

Overview:
Parametrised, multi-cycle adder/subtractor. It processes WIDTH-bit operands CHUNK bits per clock through a single CHUNK-bit ripple adder slice, carrying between slices in a register. It is the area-scalable successor to the fixed 16-bit combinational adder/subtractor: it adds a start/done handshake and reports status flags for use by datapath/ALU blocks.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK slices, NCHUNK >= 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
subtract  input  1  0: a+b, 1: a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
ready  output  1  block can accept start this cycle
done  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  sum/difference modulo 2^WIDTH
cout  output  1  carry out of MSB (subtract: 1 = no borrow, a >= b unsigned)
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]

Behaviour:
- Reset: one clock; rst_n asynchronous and active-low. While rst_n=0: state=IDLE, ready=1, done=0, result=0, cout=0, overflow=0, zero=0, negative=0, slice counter=0, carry register=0.
- States:
  - IDLE: ready=1. start=1 latches a, b, subtract and goes to RUN with counter=0 and carry=subtract.
  - RUN: ready=0. Each cycle, slice k = counter computes a[k] + (b[k] XOR subtract) + carry. The sum is written to result[k*CHUNK +: CHUNK] and carry takes the slice carry-out. counter increments; after slice NCHUNK-1, go to DONE.
  - DONE: lasts exactly one cycle; done=1, ready=1. start=1 here is accepted exactly as in IDLE and goes to RUN; otherwise go to IDLE.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E(NCHUNK). With defaults this is a 2-cycle latency.
- Throughput: one operation every NCHUNK+1 cycles (back-to-back start in DONE).
- Flag computation, on entry to DONE:
  - cout = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = (result == 0).
  - negative = result MSB.
- Output hold: result and flags hold their DONE values until the next accepted start. During RUN, result is partially updated and flags are undefined-but-stable (the implementation holds previous flags); consumers use done only.
- start while ready=0 is ignored; latched operands and subtract are unaffected.
- Input changes on a/b/subtract after acceptance have no effect.
- Reset asserted mid-RUN aborts immediately to reset values; no done pulse is produced.
- NCHUNK=1: RUN lasts one cycle; behaviour otherwise identical.

Test Plan:
- Defaults: a=23, b=3, sub=0 -> done 2 cycles after start; result=26, cout=0, ovf=0, zero=0, neg=0.
- Defaults: a=21, b=75, sub=1 -> result=0xFFCA (65482), cout=0, neg=1, ovf=0. Then a=325, b=325, sub=1 -> result=0, zero=1, cout=1.
- Overflow/carry:
  - a=16800, b=16900, sub=0 -> result=0x83A4, ovf=1, cout=0, neg=1.
  - a=0x8000, b=1, sub=1 -> result=0x7FFF, ovf=1, cout=1.
  - a=0xFFFF, b=1, sub=0 -> result=0, cout=1, zero=1.
- Handshake:
  - Pulse start during RUN with different operands -> ignored; first result unchanged.
  - Assert start in the DONE cycle -> second op accepted; its done arrives 2 cycles later.
- Reset: assert rst_n=0 mid-RUN, between clock edges -> outputs clear immediately, ready=1, no done pulse; the next op completes correctly.
- Parameter sweep: WIDTH=32, CHUNK=4, a=0x0000FFFF, b=0x00000001, sub=0 -> done 8 cycles after start, result=0x00010000, cout=0. Also WIDTH=8, CHUNK=8 (NCHUNK=1) random vs. reference model.

Source files
------------

// File: rtl/chunked_adder_subtractor.sv
// -----------------------------------------------------------------------------
// chunked_adder_subtractor
//
// Multi-cycle adder/subtractor. WIDTH-bit operands are processed CHUNK bits per
// clock through one CHUNK-bit ripple slice, with the inter-slice carry kept in
// a register. An operation takes NCHUNK = WIDTH/CHUNK RUN cycles followed by a
// single DONE cycle in which a new start may already be accepted.
//
// Parameters
//   WIDTH     operand/result width; must be an integer multiple of CHUNK
//   CHUNK     bits processed per cycle (NCHUNK >= 1)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while ready=1
//   subtract  0: a+b, 1: a-b (sampled with start)
//   a, b      operands (sampled with start)
//   ready     block can accept start this cycle (IDLE or DONE)
//   done      one-cycle pulse: result and flags valid
//   result    sum/difference modulo 2^WIDTH
//   cout      carry out of MSB (subtract: 1 = no borrow)
//   overflow  signed two's-complement overflow
//   zero      result == 0
//   negative  result[WIDTH-1]
// -----------------------------------------------------------------------------
module chunked_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the counter at least one bit wide so NCHUNK=1 still elaborates.
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic [CNT_W-1:0] count;
  logic             carry;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] result_next;
  logic             msb_carry_in;
  logic             last_slice;

  // Single shared ripple slice. Subtraction is a + ~b + 1; the +1 enters as
  // the initial carry loaded on start.
  always_comb begin
    // NOTE: every always_comb output gets a full default first (result_next
    // starts as the held result) so the partial slice write cannot infer a latch.
    result_next  = result;
    a_slice      = a_q[count*CHUNK +: CHUNK];
    b_slice      = b_q[count*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};
    slice_sum    = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
    result_next[count*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    // Carry into the slice MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    msb_carry_in = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_sum[CHUNK-1];
    last_slice   = (count == LAST_SLICE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      count    <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= subtract;
            count <= '0;
            carry <= subtract;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          result <= result_next;
          carry  <= slice_sum[CHUNK];
          count  <= count + 1'b1;
          if (last_slice) begin
            state    <= DONE;
            cout     <= slice_sum[CHUNK];
            overflow <= msb_carry_in ^ slice_sum[CHUNK];
            zero     <= (result_next == '0);
            negative <= result_next[WIDTH-1];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state != RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_chunked_adder_subtractor.sv
// -----------------------------------------------------------------------------
// tb_chunked_adder_subtractor
//
// Drives three instances of chunked_adder_subtractor:
//   d=0 : WIDTH=16, CHUNK=8  (defaults, NCHUNK=2)
//   d=1 : WIDTH=32, CHUNK=4  (NCHUNK=8)
//   d=2 : WIDTH=8,  CHUNK=8  (NCHUNK=1)
// Expected values come from directed constants and from an integer-arithmetic
// reference model (unsigned sum/difference plus signed range test).
// -----------------------------------------------------------------------------
module tb_chunked_adder_subtractor;

  typedef struct packed {
    logic [63:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;
    logic        negative;
  } out_t;

  typedef struct {
    longint unsigned a;
    longint unsigned b;
    longint unsigned r;
    bit sub, c, o, z, n;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        start0, sub0, ready0, done0, cout0, ovf0, zero0, neg0;
  logic [15:0] a0, b0, res0;
  logic        start1, sub1, ready1, done1, cout1, ovf1, zero1, neg1;
  logic [31:0] a1, b1, res1;
  logic        start2, sub2, ready2, done2, cout2, ovf2, zero2, neg2;
  logic [7:0]  a2, b2, res2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  chunked_adder_subtractor #(.WIDTH(16), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .subtract(sub0), .a(a0), .b(b0),
    .ready(ready0), .done(done0), .result(res0), .cout(cout0),
    .overflow(ovf0), .zero(zero0), .negative(neg0));

  chunked_adder_subtractor #(.WIDTH(32), .CHUNK(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .subtract(sub1), .a(a1), .b(b1),
    .ready(ready1), .done(done1), .result(res1), .cout(cout1),
    .overflow(ovf1), .zero(zero1), .negative(neg1));

  chunked_adder_subtractor #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .subtract(sub2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .result(res2), .cout(cout2),
    .overflow(ovf2), .zero(zero2), .negative(neg2));

  // ---------------------------------------------------------------- helpers
  function automatic int wid(input int d);
    case (d)
      0:       return 16;
      1:       return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int nchunk(input int d);
    case (d)
      0:       return 2;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic out_t obs(input int d);
    out_t o;
    o = '0;
    case (d)
      0: begin o.result = 64'(res0); o.cout = cout0; o.overflow = ovf0; o.zero = zero0; o.negative = neg0; end
      1: begin o.result = 64'(res1); o.cout = cout1; o.overflow = ovf1; o.zero = zero1; o.negative = neg1; end
      default: begin o.result = 64'(res2); o.cout = cout2; o.overflow = ovf2; o.zero = zero2; o.negative = neg2; end
    endcase
    return o;
  endfunction

  function automatic logic rdy(input int d);
    case (d)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  function automatic logic dn(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic drive(input int d, input bit st, input longint unsigned a,
                       input longint unsigned b, input bit sub);
    case (d)
      0: begin start0 = st; a0 = a[15:0]; b0 = b[15:0]; sub0 = sub; end
      1: begin start1 = st; a1 = a[31:0]; b1 = b[31:0]; sub1 = sub; end
      default: begin start2 = st; a2 = a[7:0]; b2 = b[7:0]; sub2 = sub; end
    endcase
  endtask

  // Reference model: plain modular arithmetic for result, unsigned comparison
  // for the carry/borrow, signed integer range test for overflow.
  function automatic out_t model(input int d, input longint unsigned a,
                                 input longint unsigned b, input bit sub);
    out_t            o;
    int              w;
    longint unsigned mask, full;
    longint          half, sa, sb, sr;
    w    = wid(d);
    mask = (64'd1 << w) - 64'd1;
    half = longint'(64'd1 << (w - 1));
    a    = a & mask;
    b    = b & mask;
    o    = '0;
    if (!sub) begin
      full     = a + b;
      o.result = full & mask;
      o.cout   = (full > mask);
    end else begin
      o.result = (a - b) & mask;
      o.cout   = (a >= b);
    end
    sa = (a >= longint'(half)) ? longint'(a) - 2 * half : longint'(a);
    sb = (b >= longint'(half)) ? longint'(b) - 2 * half : longint'(b);
    sr = sub ? sa - sb : sa + sb;
    o.overflow = (sr < -half) || (sr > half - 1);
    o.zero     = (o.result == 0);
    o.negative = o.result[w-1];
    return o;
  endfunction

  // Start one op on instance d, return at the negedge where done is seen.
  // lat counts clock edges after the accepting edge; capped at 64.
  task automatic run_op(input int d, input longint unsigned a,
                        input longint unsigned b, input bit sub, output int lat);
    @(negedge clk);
    drive(d, 1'b1, a, b, sub);
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, a, b, sub);
    lat = 0;
    while (!dn(d) && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic longint unsigned pick(input int d);
    longint unsigned mask;
    mask = (64'd1 << wid(d)) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return mask >> 1;
      3:       return (mask >> 1) + 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    #3;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (obs(d) !== out_t'(0)) $display("FAIL reset_outputs d=%0d got result=%h c=%b o=%b z=%b n=%b want all zero",
        d, obs(d).result, obs(d).cout, obs(d).overflow, obs(d).zero, obs(d).negative);
      else n_pass++;
      n_checks++;
      if ({rdy(d), dn(d)} !== 2'b10) $display("FAIL reset_handshake d=%0d got ready=%b done=%b want ready=1 done=0",
        d, rdy(d), dn(d));
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    vec_t vecs[6];
    out_t exp, got;
    int   lat;
    vecs[0] = '{64'd23,     64'd3,     64'd26,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'd21,     64'd75,    64'hFFCA,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{64'd325,    64'd325,   64'd0,      1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'd16800,  64'd16900, 64'h83A4,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{64'h8000,   64'd1,     64'h7FFF,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{64'hFFFF,   64'd1,     64'd0,      1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      exp = '{vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z, vecs[i].n};
      got = obs(0);
      n_checks++;
      if (lat !== 2) $display("FAIL directed_latency #%0d got %0d want 2", i, lat);
      else n_pass++;
      n_checks++;
      if (got !== exp) $display("FAIL directed_result #%0d got r=%h c%b o%b z%b n%b want r=%h c%b o%b z%b n%b",
        i, got.result, got.cout, got.overflow, got.zero, got.negative,
        exp.result, exp.cout, exp.overflow, exp.zero, exp.negative);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int counts[3] = '{30, 10, 30};
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < counts[d]; i++) begin
        longint unsigned a, b;
        bit   sub;
        int   lat;
        out_t exp, got;
        a   = pick(d);
        b   = pick(d);
        sub = 1'($urandom_range(0, 1));
        run_op(d, a, b, sub, lat);
        exp = model(d, a, b, sub);
        got = obs(d);
        n_checks++;
        if (lat !== nchunk(d) || got !== exp)
          $display("FAIL random d=%0d a=%h b=%h sub=%b lat=%0d/%0d got r=%h c%b o%b z%b n%b want r=%h c%b o%b z%b n%b",
            d, a, b, sub, lat, nchunk(d), got.result, got.cout, got.overflow, got.zero, got.negative,
            exp.result, exp.cout, exp.overflow, exp.zero, exp.negative);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sweep32;
    int lat;
    run_op(1, 64'h0000FFFF, 64'h00000001, 1'b0, lat);
    n_checks++;
    if (lat !== 8) $display("FAIL sweep32_latency got %0d want 8", lat);
    else n_pass++;
    n_checks++;
    if (obs(1) !== out_t'{64'h00010000, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL sweep32_result got r=%h c=%b want r=00010000 c=0", obs(1).result, obs(1).cout);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int   lat;
    out_t exp;
    exp = model(0, 64'h1234, 64'h0F0F, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 64'h1234, 64'h0F0F, 1'b1);
    @(posedge clk);
    @(negedge clk);
    // Busy: new request with different operands must be dropped.
    drive(0, 1'b1, 64'hAAAA, 64'h5555, 1'b0);
    n_checks++;
    if (ready0 !== 1'b0) $display("FAIL ignore_ready_in_run got %b want 0", ready0);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 64'hFFFF, 64'hFFFF, 1'b0);
    lat = 1;
    while (!done0 && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 2 || obs(0) !== exp)
      $display("FAIL ignore_result lat=%0d got r=%h c=%b want lat=2 r=%h c=%b",
        lat, obs(0).result, obs(0).cout, exp.result, exp.cout);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ready0, done0} !== 2'b10)
      $display("FAIL ignore_no_queued_op got ready=%b done=%b want ready=1 done=0", ready0, done0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int   lat;
    out_t exp;
    run_op(0, 64'h7FFF, 64'h0001, 1'b0, lat);
    n_checks++;
    if (ready0 !== 1'b1) $display("FAIL b2b_ready_in_done got %b want 1", ready0);
    else n_pass++;
    // Second op accepted in the DONE cycle.
    exp = model(0, 64'h0100, 64'h0200, 1'b1);
    drive(0, 1'b1, 64'h0100, 64'h0200, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 64'h0, 64'h0, 1'b0);
    n_checks++;
    if ({ready0, done0} !== 2'b00)
      $display("FAIL b2b_accepted got ready=%b done=%b want ready=0 done=0", ready0, done0);
    else n_pass++;
    lat = 0;
    while (!done0 && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 2 || obs(0) !== exp)
      $display("FAIL b2b_second lat=%0d got r=%h c=%b n=%b want lat=2 r=%h c=%b n=%b",
        lat, obs(0).result, obs(0).cout, obs(0).negative, exp.result, exp.cout, exp.negative);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int   lat;
    bit   saw_done;
    out_t exp;
    @(negedge clk);
    drive(0, 1'b1, 64'h1234, 64'h1111, 1'b0);
    @(posedge clk);
    #2;
    drive(0, 1'b0, 64'h1234, 64'h1111, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs(0) !== out_t'(0) || {ready0, done0} !== 2'b10)
      $display("FAIL midrun_reset got r=%h c=%b ready=%b done=%b want r=0 c=0 ready=1 done=0",
        obs(0).result, obs(0).cout, ready0, done0);
    else n_pass++;
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL midrun_no_done got done pulse=%b want 0", saw_done);
    else n_pass++;
    exp = model(0, 64'hC000, 64'h4001, 1'b0);
    run_op(0, 64'hC000, 64'h4001, 1'b0, lat);
    n_checks++;
    if (lat !== 2 || obs(0) !== exp)
      $display("FAIL midrun_next_op lat=%0d got r=%h c=%b o=%b want lat=2 r=%h c=%b o=%b",
        lat, obs(0).result, obs(0).cout, obs(0).overflow, exp.result, exp.cout, exp.overflow);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(2, 1'b0, 64'd0, 64'd0, 1'b0);
    test_reset();
    test_directed();
    test_sweep32();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
